sixty_four_bit_adder: RTL and testbench
=======================================

# sixty_four_bit_adder

64-bit two's-complement/unsigned adder with carry-in and carry-out, the integer add datapath of the ALU. Produces a zero-latency combinational result, plus a registered copy of the result for pipelined consumers. Built from 4-bit carry-lookahead groups with a second-level group lookahead, not a flat ripple chain.

## Interface
- No parameters; width fixed at 64.
- clk  input  1  single clock; rising-edge active for all registers.
- rst  input  1  synchronous, active-high reset.
- a  input  64  operand A.
- b  input  64  operand B.
- c_in  input  1  carry into bit 0.
- sum  output  64  combinational a + b + c_in, low 64 bits.
- c_out  output  1  combinational carry out of bit 63.
- ovf  output  1  combinational signed overflow: (a[63] == b[63]) && (sum[63] != a[63]).
- sum_q  output  64  sum registered on clk.
- c_out_q  output  1  c_out registered on clk.
- ovf_q  output  1  ovf registered on clk.

## Operation
- Full 65-bit result {c_out, sum} = a + b + c_in, with all operands treated as unsigned.
- Bit level: generate g[i] = a[i]&b[i], propagate p[i] = a[i]^b[i], sum[i] = p[i]^c[i].
- Sixteen 4-bit CLA groups, each producing group G/P. A second-level lookahead over groups 0..15 (four blocks of four, then the top level) computes the group carry-ins from c_in. c_out is the carry out of group 15.
- ovf uses the signed interpretation only; it does not affect sum or c_out.
- The combinational outputs depend only on a, b and c_in. They are independent of clk and rst, including while rst is high.
- Registered outputs:
  - On each rising clk with rst=1: sum_q, c_out_q and ovf_q go to 0.
  - Otherwise they capture sum, c_out and ovf.
- No enables, no handshake, no internal state besides the output registers.
- No X propagation from unused logic. Outputs are fully determined whenever the inputs are 0/1.

## Timing
- Combinational outputs: zero-cycle latency. They must be valid within 10 ns of an input change at the target clock, and the bench samples 10 ns after applying inputs.
- Registered outputs: latency of 1 cycle. A value applied before rising edge N appears on the *_q outputs after edge N.
- Reset value of every registered output is 0. Reset asserted mid-stream clears the *_q outputs on the next edge; the combinational outputs keep tracking the inputs.
- Power-up, before the first reset edge: *_q outputs are undefined. Consumers must reset first.
- Critical path: c_in → group lookahead → bit 63 sum. It must not be a 64-stage ripple.

## Test plan
- a=0, b=0, c_in=0 → sum=0, c_out=0, ovf=0. After one clk, sum_q=0.
- a=64'hFFFF_FFFF_FFFF_FFFF, b=0, c_in=1 → sum=0, c_out=1, ovf=0. This exercises the full carry chain through all 16 groups.
- a=64'h7FFF_FFFF_FFFF_FFFF, b=1, c_in=0 → sum=64'h8000_0000_0000_0000, c_out=0, ovf=1.
- a=64'h8000_0000_0000_0000, b=64'h8000_0000_0000_0000, c_in=0 → sum=0, c_out=1, ovf=1.
- a=64'h0123_4567_89AB_CDEF, b=64'hFEDC_BA98_7654_3210, c_in=1 → sum=0, c_out=1. Then apply rst=1 for one edge → sum_q=0, c_out_q=0, ovf_q=0, while sum and c_out are unchanged.
- Random vectors (≥10k), compared each cycle against the 65-bit reference a+b+c_in. Also check that *_q equals the previous cycle's combinational outputs.

Source files
------------

// File: rtl/sixty_four_bit_adder.sv
// 64-bit adder built from two-level carry lookahead: bit -> 4-bit group -> block of 4 groups -> top.
// Provides a combinational result plus a registered copy for pipelined consumers.
module sixty_four_bit_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        c_in,
  output logic [63:0] sum,
  output logic        c_out,
  output logic        ovf,
  output logic [63:0] sum_q,
  output logic        c_out_q,
  output logic        ovf_q
);

  // Lookahead generate over four (g, p) pairs, index 3 most significant.
  function automatic logic grp_g(input logic [3:0] g, input logic [3:0] p);
    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  function automatic logic grp_p(input logic [3:0] p);
    grp_p = &p;
  endfunction

  // Carries into positions 1..3 of a four-wide slice, all expanded from ci (no ripple).
  function automatic logic [2:0] cla3(input logic [2:0] g, input logic [2:0] p, input logic ci);
    cla3[0] = g[0] | (p[0] & ci);
    cla3[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    cla3[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  endfunction

  logic [63:0] w_g;
  logic [63:0] w_p;
  logic [63:0] w_c;
  logic [15:0] w_gg;
  logic [15:0] w_gp;
  logic [15:0] w_gc;
  logic [2:0]  w_bg;
  logic [2:0]  w_bp;
  logic [3:0]  w_bc;

  assign w_g = a & b;
  assign w_p = a ^ b;

  for (genvar k = 0; k < 16; k++) begin : g_grp
    assign w_gg[k] = grp_g(w_g[4*k +: 4], w_p[4*k +: 4]);
    assign w_gp[k] = grp_p(w_p[4*k +: 4]);
  end

  // Block 3 only needs its carry-in; its own G/P would feed nothing.
  for (genvar j = 0; j < 3; j++) begin : g_blk_gp
    assign w_bg[j] = grp_g(w_gg[4*j +: 4], w_gp[4*j +: 4]);
    assign w_bp[j] = grp_p(w_gp[4*j +: 4]);
  end

  assign w_bc[0]   = c_in;
  assign w_bc[3:1] = cla3(w_bg, w_bp, c_in);

  for (genvar j = 0; j < 4; j++) begin : g_blk_c
    assign w_gc[4*j]        = w_bc[j];
    assign w_gc[4*j+1 +: 3] = cla3(w_gg[4*j +: 3], w_gp[4*j +: 3], w_bc[j]);
  end

  for (genvar k = 0; k < 16; k++) begin : g_bit_c
    assign w_c[4*k]        = w_gc[k];
    assign w_c[4*k+1 +: 3] = cla3(w_g[4*k +: 3], w_p[4*k +: 3], w_gc[k]);
  end

  assign sum   = w_p ^ w_c;
  assign c_out = w_gg[15] | (w_gp[15] & w_gc[15]);
  assign ovf   = (a[63] == b[63]) && (sum[63] != a[63]);

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sum_q   <= sum;
      c_out_q <= c_out;
      ovf_q   <= ovf;
    end
  end

endmodule

// File: tb/tb_sixty_four_bit_adder.sv
// Randomized scoreboard bench for sixty_four_bit_adder against a wide-integer reference model.
module tb_sixty_four_bit_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        c_in = 1'b0;
  logic [63:0] sum;
  logic        c_out;
  logic        ovf;
  logic [63:0] sum_q;
  logic        c_out_q;
  logic        ovf_q;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ov;
    logic        chk_q;
    logic [63:0] qs;
    logic        qco;
    logic        qov;
  } exp_t;

  exp_t sb[$];

  logic [63:0] prev_s = '0;
  logic        prev_co = 1'b0;
  logic        prev_ov = 1'b0;
  logic        prev_rst = 1'b1;
  logic        prev_known = 1'b0;

  sixty_four_bit_adder dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .c_in   (c_in),
    .sum    (sum),
    .c_out  (c_out),
    .ovf    (ovf),
    .sum_q  (sum_q),
    .c_out_q(c_out_q),
    .ovf_q  (ovf_q)
  );

  always #15 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: plain wide-integer arithmetic; overflow = signed result does not fit in 64 bits.
  task automatic apply(input logic [63:0] ta, input logic [63:0] tb_b, input logic tc, input logic tr);
    exp_t e;
    logic [64:0] full;
    logic signed [65:0] ss;
    @(posedge clk);
    #2;
    a = ta;
    b = tb_b;
    c_in = tc;
    rst = tr;
    full = {1'b0, ta} + {1'b0, tb_b} + {64'd0, tc};
    ss = $signed({{2{ta[63]}}, ta}) + $signed({{2{tb_b[63]}}, tb_b}) + $signed({65'd0, tc});
    e.s = full[63:0];
    e.co = full[64];
    e.ov = (ss != $signed({{2{ss[63]}}, ss[63:0]}));
    e.chk_q = prev_known;
    e.qs  = prev_rst ? 64'd0 : prev_s;
    e.qco = prev_rst ? 1'b0 : prev_co;
    e.qov = prev_rst ? 1'b0 : prev_ov;
    sb.push_back(e);
    prev_s = e.s;
    prev_co = e.co;
    prev_ov = e.ov;
    prev_rst = tr;
    prev_known = 1'b1;
  endtask

  // Monitor: 10 ns after each input update, compare combinational and registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #12;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sum", sum, e.s);
        chk("c_out", {63'd0, c_out}, {63'd0, e.co});
        chk("ovf", {63'd0, ovf}, {63'd0, e.ov});
        if (e.chk_q) begin
          chk("sum_q", sum_q, e.qs);
          chk("c_out_q", {63'd0, c_out_q}, {63'd0, e.qco});
          chk("ovf_q", {63'd0, ovf_q}, {63'd0, e.qov});
        end
      end
    end
  end

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rc;
    logic        rr;
    logic [63:0] edge_vals [4];
    edge_vals[0] = 64'h0;
    edge_vals[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    edge_vals[2] = 64'h7FFF_FFFF_FFFF_FFFF;
    edge_vals[3] = 64'h8000_0000_0000_0000;

    apply(64'h0, 64'h0, 1'b0, 1'b1);
    apply(64'h0, 64'h0, 1'b0, 1'b1);

    apply(64'h0, 64'h0, 1'b0, 1'b0);
    #10;
    chk("dir_zero_sum", sum, 64'h0);
    chk("dir_zero_q_reset", sum_q, 64'h0);
    apply(64'h0, 64'h0, 1'b0, 1'b0);

    apply(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    #10;
    chk("dir_chain_sum", sum, 64'h0);
    chk("dir_chain_cout", {63'd0, c_out}, 64'd1);
    chk("dir_chain_ovf", {63'd0, ovf}, 64'd0);

    apply(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    #10;
    chk("dir_posovf_sum", sum, 64'h8000_0000_0000_0000);
    chk("dir_posovf_ovf", {63'd0, ovf}, 64'd1);
    chk("dir_posovf_cout", {63'd0, c_out}, 64'd0);

    apply(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    #10;
    chk("dir_negovf_sum", sum, 64'h0);
    chk("dir_negovf_cout", {63'd0, c_out}, 64'd1);
    chk("dir_negovf_ovf", {63'd0, ovf}, 64'd1);

    apply(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
    apply(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b1);
    apply(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
    #10;
    chk("dir_midrst_sum_q", sum_q, 64'h0);
    chk("dir_midrst_cout_q", {63'd0, c_out_q}, 64'd0);
    chk("dir_midrst_sum", sum, 64'h0);
    chk("dir_midrst_cout", {63'd0, c_out}, 64'd1);

    for (int i = 0; i < 10000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: ;
        1: rb = ~ra;
        2: rb = 64'($urandom_range(0, 15));
        default: begin
          ra = edge_vals[$urandom_range(0, 3)];
          rb = edge_vals[$urandom_range(0, 3)];
        end
      endcase
      rr = ($urandom_range(0, 63) == 0);
      apply(ra, rb, rc, rr);
    end

    repeat (3) @(posedge clk);
    #20;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
